// File: rtl/timer_pkg.sv
// timer_pkg: timer register map, TCR/TSR bit positions and sequencer state types
package timer_pkg;
  localparam logic [7:0] TDR_OFF = 8'h00;
  localparam logic [7:0] TCR_OFF = 8'h01;
  localparam logic [7:0] TSR_OFF = 8'h02;
  localparam int TCR_LOAD = 7;
  localparam int TCR_DW = 5;
  localparam int TCR_EN = 4;
  localparam int TSR_UDF = 1;
  localparam int TSR_OVF = 0;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_RUN, S_GAP, S_RD_TSR, S_CLR_TSR, S_WR_STOP
  } seq_state_e;
  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_e;
  // Build a TCR value from its fields; clock select occupies bits [1:0].
  function automatic logic [7:0] tcr_word(input logic load, input logic dw, input logic en,
                                          input logic [1:0] cks);
    logic [7:0] w;
    w = 8'h00;
    w[TCR_LOAD] = load;
    w[TCR_DW] = dw;
    w[TCR_EN] = en;
    w[1:0] = cks;
    return w;
  endfunction
endpackage

// File: rtl/timer_apb_xfer.sv
// timer_apb_xfer: single-transfer APB master engine (SETUP then ACCESS until pready)
module timer_apb_xfer
  import timer_pkg::*;
(
  input  logic       pclk,
  input  logic       preset,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       write_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       slverr_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  input  logic       pslverr_i
);
  xfer_state_e state_q, state_d;
  logic [7:0] paddr_q, pwdata_q;
  logic pwrite_q;
  // Advance SETUP->ACCESS unconditionally; ACCESS holds until the slave is ready.
  always_comb begin
    state_d = (state_q == X_IDLE && start_i) ? X_SETUP
            : (state_q == X_SETUP) ? X_ACCESS
            : (state_q == X_ACCESS && pready_i) ? X_IDLE
            : state_q;
  end
  // State register; address, direction and data are frozen for the whole transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= X_IDLE;
      paddr_q <= 8'h00;
      pwdata_q <= 8'h00;
      pwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == X_IDLE && start_i) begin
        paddr_q <= addr_i;
        pwdata_q <= wdata_i;
        pwrite_q <= write_i;
      end
    end
  end
  assign psel_o = state_q != X_IDLE;
  assign penable_o = state_q == X_ACCESS;
  assign pwrite_o = pwrite_q;
  assign paddr_o = paddr_q;
  assign pwdata_o = pwdata_q;
  assign done_o = penable_o & pready_i;
  assign rdata_o = prdata_i;
  assign slverr_o = pslverr_i;
endmodule

// File: rtl/timer_apb_sequencer.sv
// timer_apb_sequencer: programs the 8-bit timer over APB, polls its flag, counts events, stops it
module timer_apb_sequencer
  import timer_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter logic [7:0] TMR_BASE = 8'h00
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_reload,
  input  logic       cmd_dw,
  input  logic [1:0] cmd_cks,
  input  logic [7:0] cmd_nevt,
  input  logic       abort,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       evt_pulse,
  output logic [7:0] evt_cnt,
  output logic       done,
  output logic       err
);
  localparam int GW = $clog2(POLL_GAP + 1);
  seq_state_e state_q, state_d, seq_next;
  logic [7:0] reload_q, nevt_q, evt_cnt_q;
  logic [1:0] cks_q;
  logic dw_q, launched_q, abort_q, evt_pulse_q, done_q, err_q;
  logic [GW-1:0] gap_q;
  logic accept, start, x_done, x_slverr, x_write, stop_req, flag, evt_hit, last_evt, gap_end;
  logic [7:0] x_addr, x_wdata, x_rdata;
  timer_apb_xfer u_xfer (
    .pclk(pclk), .preset(preset), .start_i(start), .addr_i(x_addr), .wdata_i(x_wdata),
    .write_i(x_write), .done_o(x_done), .rdata_o(x_rdata), .slverr_o(x_slverr),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );
  // Decode the transfer owned by the current state and the routing after it completes.
  always_comb begin
    accept = cmd_valid & cmd_ready;
    start = !launched_q && state_q != S_IDLE && state_q != S_GAP;
    stop_req = abort_q | abort;
    flag = x_rdata[dw_q ? TSR_UDF : TSR_OVF];
    evt_hit = state_q == S_CLR_TSR && x_done && !x_slverr;
    last_evt = nevt_q != 8'h00 && evt_cnt_q + 8'd1 == nevt_q;
    gap_end = gap_q == GW'(POLL_GAP - 1);
    x_write = state_q != S_RD_TSR;
    x_addr = TMR_BASE + (state_q == S_WR_TDR ? TDR_OFF
                       : (state_q == S_RD_TSR || state_q == S_CLR_TSR) ? TSR_OFF : TCR_OFF);
    x_wdata = state_q == S_WR_TDR ? reload_q
            : state_q == S_WR_LOAD ? tcr_word(1'b1, dw_q, 1'b0, cks_q)
            : state_q == S_WR_RUN ? tcr_word(1'b0, dw_q, 1'b1, cks_q)
            : state_q == S_WR_STOP ? tcr_word(1'b0, dw_q, 1'b0, cks_q)
            : 8'h00;
    seq_next = state_q == S_WR_TDR ? S_WR_LOAD
             : state_q == S_WR_LOAD ? S_WR_RUN
             : (state_q == S_CLR_TSR && last_evt) ? S_WR_STOP
             : S_GAP;
    state_d = state_q == S_IDLE ? (accept ? S_WR_TDR : S_IDLE)
            : state_q == S_GAP ? (stop_req ? S_WR_STOP : gap_end ? S_RD_TSR : S_GAP)
            : !x_done ? state_q
            : state_q == S_WR_STOP ? S_IDLE
            : x_slverr ? S_WR_STOP
            : (state_q == S_RD_TSR && flag) ? S_CLR_TSR
            : stop_req ? S_WR_STOP
            : seq_next;
  end
  // State, command latch, abort latch, poll gap timer and event/status registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
      reload_q <= 8'h00;
      nevt_q <= 8'h00;
      cks_q <= 2'b00;
      dw_q <= 1'b0;
      launched_q <= 1'b0;
      abort_q <= 1'b0;
      gap_q <= '0;
      evt_cnt_q <= 8'h00;
      evt_pulse_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        reload_q <= cmd_reload;
        nevt_q <= cmd_nevt;
        cks_q <= cmd_cks;
        dw_q <= cmd_dw;
      end
      launched_q <= start ? 1'b1 : x_done ? 1'b0 : launched_q;
      abort_q <= state_d != S_IDLE && (abort_q || (busy && abort));
      gap_q <= state_q == S_GAP ? gap_q + 1'b1 : '0;
      evt_cnt_q <= accept ? 8'h00 : evt_hit ? evt_cnt_q + 8'd1 : evt_cnt_q;
      evt_pulse_q <= evt_hit;
      done_q <= state_q != S_IDLE && state_d == S_IDLE;
      err_q <= accept ? 1'b0 : (x_done && x_slverr) ? 1'b1 : err_q;
    end
  end
  assign cmd_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign evt_pulse = evt_pulse_q;
  assign evt_cnt = evt_cnt_q;
  assign done = done_q;
  assign err = err_q;
endmodule
